// File: rtl/prio_rr_arbiter.sv
// N-way registered grant engine with fixed-priority or round-robin selection,
// hold-until-release handshake, forced release after MAX_HOLD cycles and contention stats.
module prio_rr_arbiter #(
   parameter int N        = 4,
   parameter int MODE     = 0,
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic                 ack,
   output logic [N-1:0]         gnt,
   output logic                 gnt_valid,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 timeout,
   output logic                 contention,
   output logic [CNT_W-1:0]     contention_cnt
);
   localparam int                ID_W     = $clog2(N);
   localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0]  CNT_SAT  = {CNT_W{1'b1}};
   localparam logic [N-1:0]      ONE_LSB  = {{(N-1){1'b0}}, 1'b1};
   localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(N - 1);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

   state_t            r_state, w_state_nxt;
   logic [N-1:0]      r_gnt, w_gnt_nxt;
   logic              r_gnt_valid;
   logic [ID_W-1:0]   r_gnt_id, w_gnt_id_nxt;
   logic [ID_W-1:0]   r_ptr, w_ptr_nxt;
   logic [HOLD_W-1:0] r_hold, w_hold_nxt;
   logic              r_timeout, w_timeout_nxt;
   logic              r_contention, w_contention_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic              w_win_found;
   logic [ID_W-1:0]   w_win_id;
   logic              w_withdraw, w_expire, w_release;

   // True when two or more bits are set: clearing the lowest set bit leaves something behind.
   function automatic logic multi_hot(input logic [N-1:0] v);
      return (v & (v - ONE_LSB)) != {N{1'b0}};
   endfunction

   // Winner search: first set request at or above ptr, wrapping; ptr stays 0 in fixed mode.
   always_comb begin
      int idx;
      idx         = 0;
      w_win_found = 1'b0;
      w_win_id    = '0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(r_ptr) + i) % N;
         if (!w_win_found && req[idx[ID_W-1:0]]) begin
            w_win_found = 1'b1;
            w_win_id    = idx[ID_W-1:0];
         end else begin
            w_win_found = w_win_found;
         end
      end
   end

   assign w_withdraw = ~req[r_gnt_id];
   assign w_expire   = (r_hold == HOLD_MAX);
   assign w_release  = (r_state == S_GRANT) && (ack || w_withdraw || w_expire);

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_win_found) w_state_nxt = S_GRANT;
            else             w_state_nxt = S_IDLE;
         end
         S_GRANT: begin
            if (w_release) w_state_nxt = S_IDLE;
            else           w_state_nxt = S_GRANT;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Next values of every registered output and of the pointer/hold counter.
   always_comb begin
      w_gnt_nxt        = r_gnt;
      w_gnt_id_nxt     = r_gnt_id;
      w_ptr_nxt        = r_ptr;
      w_hold_nxt       = r_hold;
      w_timeout_nxt    = 1'b0;
      w_contention_nxt = 1'b0;
      w_cnt_nxt        = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_win_found) begin
               w_gnt_nxt        = ONE_LSB << w_win_id;
               w_gnt_id_nxt     = w_win_id;
               w_hold_nxt       = HOLD_W'(1);
               w_contention_nxt = multi_hot(req);
               if (multi_hot(req) && (r_cnt != CNT_SAT)) w_cnt_nxt = r_cnt + CNT_W'(1);
               else                                      w_cnt_nxt = r_cnt;
            end else begin
               w_gnt_nxt = '0;
            end
         end
         S_GRANT: begin
            if (w_release) begin
               w_gnt_nxt     = '0;
               w_gnt_id_nxt  = '0;
               w_hold_nxt    = '0;
               // ack and withdraw both outrank the hold limit
               w_timeout_nxt = ~ack & ~w_withdraw & w_expire;
               if (MODE == 1) w_ptr_nxt = (r_gnt_id == ID_LAST) ? '0 : r_gnt_id + ID_W'(1);
               else           w_ptr_nxt = '0;
            end else begin
               w_hold_nxt = r_hold + HOLD_W'(1);
            end
         end
         default: begin
            w_gnt_nxt    = '0;
            w_gnt_id_nxt = '0;
            w_hold_nxt   = '0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_gnt        <= '0;
         r_gnt_valid  <= 1'b0;
         r_gnt_id     <= '0;
         r_ptr        <= '0;
         r_hold       <= '0;
         r_timeout    <= 1'b0;
         r_contention <= 1'b0;
         r_cnt        <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_gnt        <= w_gnt_nxt;
         r_gnt_valid  <= |w_gnt_nxt;
         r_gnt_id     <= w_gnt_id_nxt;
         r_ptr        <= w_ptr_nxt;
         r_hold       <= w_hold_nxt;
         r_timeout    <= w_timeout_nxt;
         r_contention <= w_contention_nxt;
         r_cnt        <= w_cnt_nxt;
      end
   end

   assign gnt            = r_gnt;
   assign gnt_valid      = r_gnt_valid;
   assign gnt_id         = r_gnt_id;
   assign timeout        = r_timeout;
   assign contention     = r_contention;
   assign contention_cnt = r_cnt;
endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Directed bench: a fixed-priority arbiter (2-bit counter) and a round-robin arbiter
// share one stimulus stream; each scenario checks the instance it targets.
module tb_prio_rr_arbiter;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         ack;
   logic [N-1:0] req;

   logic [N-1:0] fp_gnt, rr_gnt;
   logic         fp_gnt_valid, rr_gnt_valid;
   logic [1:0]   fp_gnt_id, rr_gnt_id;
   logic         fp_timeout, rr_timeout;
   logic         fp_contention, rr_contention;
   logic [1:0]   fp_cnt;
   logic [15:0]  rr_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   prio_rr_arbiter #(.N(N), .MODE(0), .MAX_HOLD(16), .CNT_W(2)) u_fp (
      .clk(clk), .rst(rst), .req(req), .ack(ack),
      .gnt(fp_gnt), .gnt_valid(fp_gnt_valid), .gnt_id(fp_gnt_id),
      .timeout(fp_timeout), .contention(fp_contention), .contention_cnt(fp_cnt)
   );

   prio_rr_arbiter #(.N(N), .MODE(1), .MAX_HOLD(16), .CNT_W(16)) u_rr (
      .clk(clk), .rst(rst), .req(req), .ack(ack),
      .gnt(rr_gnt), .gnt_valid(rr_gnt_valid), .gnt_id(rr_gnt_id),
      .timeout(rr_timeout), .contention(rr_contention), .contention_cnt(rr_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1; req = '0; ack = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int held;
      int order [5] = '{0, 1, 2, 3, 0};

      rst = 1'b1; req = '0; ack = 1'b0;
      tick(); tick();
      check_eq("rst_gnt",        fp_gnt, 4'b0000);
      check_eq("rst_valid",      fp_gnt_valid, 1'b0);
      check_eq("rst_id",         fp_gnt_id, 2'd0);
      check_eq("rst_timeout",    fp_timeout, 1'b0);
      check_eq("rst_contention", fp_contention, 1'b0);
      check_eq("rst_cnt",        rr_cnt, 16'd0);
      rst = 1'b0;

      // Reset in the middle of a held grant
      req = 4'b0100;
      tick(); tick(); tick();
      check_eq("mid_gnt_held", fp_gnt, 4'b0100);
      check_eq("mid_id_held",  fp_gnt_id, 2'd2);
      check_eq("mid_valid",    fp_gnt_valid, 1'b1);
      rst = 1'b1;
      tick();
      check_eq("mid_rst_gnt",   fp_gnt, 4'b0000);
      check_eq("mid_rst_valid", fp_gnt_valid, 1'b0);
      check_eq("mid_rst_id",    fp_gnt_id, 2'd0);
      check_eq("mid_rst_rrgnt", rr_gnt, 4'b0000);
      rst = 1'b0;
      tick();
      check_eq("mid_regrant", fp_gnt, 4'b0100);

      // Withdraw of the owner's request
      req = 4'b0000;
      tick();
      check_eq("wd_gnt",     fp_gnt, 4'b0000);
      check_eq("wd_timeout", fp_timeout, 1'b0);
      check_eq("wd_valid",   fp_gnt_valid, 1'b0);

      // Fixed priority with contention, then counter saturation at 3
      pulse_reset();
      req = 4'b1010;
      tick();
      check_eq("fp_gnt",        fp_gnt, 4'b0010);
      check_eq("fp_id",         fp_gnt_id, 2'd1);
      check_eq("fp_contention", fp_contention, 1'b1);
      check_eq("fp_cnt1",       fp_cnt, 2'd1);
      ack = 1'b1;
      tick();
      check_eq("fp_rel_gnt",  fp_gnt, 4'b0000);
      check_eq("fp_rel_cont", fp_contention, 1'b0);
      ack = 1'b0;
      tick();
      check_eq("fp_regnt", fp_gnt, 4'b0010);
      check_eq("fp_cnt2",  fp_cnt, 2'd2);
      for (int k = 0; k < 3; k++) begin
         ack = 1'b1; tick();
         ack = 1'b0; tick();
      end
      check_eq("fp_cnt_sat",      fp_cnt, 2'd3);
      check_eq("fp_cnt_sat_cont", fp_contention, 1'b1);

      // Round-robin over all four requesters
      pulse_reset();
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         check_eq("rr_order_id",  rr_gnt_id, order[k]);
         check_eq("rr_order_gnt", rr_gnt, 4'b0001 << order[k]);
         check_eq("rr_order_con", rr_contention, 1'b1);
         ack = 1'b1;
         tick();
         check_eq("rr_gap", rr_gnt, 4'b0000);
         ack = 1'b0;
      end
      check_eq("rr_cnt5", rr_cnt, 16'd5);

      // Round-robin wrap: ptr=3 after granting id 2
      pulse_reset();
      req = 4'b0100;
      tick();
      check_eq("wrap_first", rr_gnt_id, 2'd2);
      ack = 1'b1;
      tick();
      ack = 1'b0; req = 4'b0011;
      tick();
      check_eq("wrap_id0",  rr_gnt_id, 2'd0);
      check_eq("wrap_gnt0", rr_gnt, 4'b0001);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      tick();
      check_eq("wrap_ptr1", rr_gnt_id, 2'd1);

      // Timeout after MAX_HOLD cycles, regrant, then ack in the limit cycle
      pulse_reset();
      req = 4'b0001;
      tick();
      held = 0;
      while (fp_gnt != 4'b0000 && held < 40) begin
         held++;
         tick();
      end
      check_eq("to_len",      held, 16);
      check_eq("to_pulse",    fp_timeout, 1'b1);
      check_eq("to_rr_pulse", rr_timeout, 1'b1);
      tick();
      check_eq("to_regrant",   fp_gnt, 4'b0001);
      check_eq("to_pulse_end", fp_timeout, 1'b0);
      for (int k = 0; k < 15; k++) tick();
      check_eq("to_still_held", fp_gnt, 4'b0001);
      ack = 1'b1;
      tick();
      check_eq("to_ack_wins",  fp_timeout, 1'b0);
      check_eq("to_ack_rel",   fp_gnt, 4'b0000);
      ack = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got time-limit expiry, expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/prio_rr_arbiter.md
# prio_rr_arbiter

Parametrised N-way request arbiter that turns the team's priority-select logic into a registered, handshaked grant engine. It supports fixed-priority (lowest index wins) or round-robin selection. It holds each grant until the owner acknowledges or withdraws, and it force-releases a grant that is held too long. It sits in front of shared resources such as bus ports and shared buffers, and it exports contention statistics for debug.

## Interface
- N, 4: number of requesters, 2..32.
- MODE, 0: 0 = fixed priority (index 0 highest); 1 = round-robin.
- MAX_HOLD, 16: cycles a grant may be held before forced release, ≥2.
- CNT_W, 16: width of the contention counter.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N  request vector, level-sensitive.
- ack  in  1  grant owner done; releases the current grant.
- gnt  out  N  registered one-hot grant.
- gnt_valid  out  1  high while any grant is held.
- gnt_id  out  $clog2(N)  index of the granted requester; 0 when no grant.
- timeout  out  1  one-cycle pulse when a grant is force-released.
- contention  out  1  one-cycle pulse when more than one req is set at an arbitration decision.
- contention_cnt  out  CNT_W  saturating count of contention pulses.

## Operation
- Reset: on rst, gnt=0, gnt_valid=0, gnt_id=0, timeout=0, contention=0, contention_cnt=0, rr pointer=0, hold counter=0, state IDLE. rst has priority over all other inputs.
- States: IDLE and GRANT.
- IDLE:
  - If req≠0, select a winner and go to GRANT; gnt and gnt_id register the winner.
  - If req=0, stay in IDLE.
- Fixed-priority selection: the lowest set index of req wins.
- Round-robin selection: the first set index at or above ptr wins, scanning upward and wrapping from N-1 to 0.
- Round-robin pointer update: on every grant release (ack, withdraw or timeout), ptr ← (gnt_id+1) mod N. In MODE=0 ptr is unused and stays 0.
- GRANT: the grant is held and the hold counter increments each cycle, starting at 1 on the first GRANT cycle. The grant releases on the first of these conditions:
  1. ack=1: normal release.
  2. req[gnt_id]=0: withdraw; no timeout pulse.
  3. hold counter = MAX_HOLD with neither 1 nor 2 true: timeout=1 for one cycle.
- On release: gnt ← 0, gnt_valid ← 0, gnt_id ← 0, and the state returns to IDLE.
- Simultaneous release conditions: ack and withdraw together count as a normal release. ack arriving in the MAX_HOLD cycle wins over timeout.
- ack while in IDLE is ignored.
- Changes to req while in GRANT do not affect the current grant, except a withdraw of req[gnt_id].
- Contention:
  - contention is asserted in the cycle the new grant appears when popcount(req) ≥ 2 at the IDLE decision.
  - contention_cnt increments with each pulse and saturates at 2^CNT_W-1 without wrapping.
- Invariant: gnt is always one-hot or zero. gnt_valid = |gnt. gnt_id matches the set bit of gnt.

## Timing
- Grant latency: req sampled at edge k while in IDLE → gnt valid after edge k (visible in cycle k+1).
- Release latency: release condition sampled at edge m → gnt low after edge m.
- Back-to-back grants: at least one cycle of gnt=0 between consecutive grants. Arbitration happens in that IDLE cycle using the already-updated ptr.
- Maximum grant length is MAX_HOLD cycles.
- timeout and contention are registered pulses lasting exactly one cycle.
- No combinational path from req or ack to any output.

## Test plan
- Reset mid-grant: N=4, MODE=0, req=4'b0100, grant held for 3 cycles, then rst=1 for one cycle. Required: all outputs 0 on the next cycle. After rst=0 with req still set, gnt=4'b0100 again one cycle later.
- Fixed priority: MODE=0, req=4'b1010. Required: gnt=4'b0010, gnt_id=1, contention=1, contention_cnt=1. Then ack=1 → gnt=0 for one cycle, then gnt=4'b0010 again.
- Round-robin: MODE=1, req=4'b1111 held high, ack pulsed once per grant. Required grant order: 0,1,2,3,0. Each grant has contention=1; contention_cnt=5.
- Round-robin wrap: MODE=1, ptr=3 (after granting id 2), req=4'b0011. Required: gnt_id=0, then ptr=1 after release.
- Timeout: MAX_HOLD=16, req=4'b0001 held, ack never asserted. Required: gnt high for exactly 16 cycles; timeout pulses in the release cycle. A regrant to id 0 follows after one idle cycle.
- Withdraw and contention saturation:
  - gnt_id=2 and req[2] dropped: gnt clears next cycle, with timeout=0.
  - With CNT_W=2, 5 contention events leave contention_cnt=3.
